max_sum_index_core: RTL and testbench
=====================================

# max_sum_index_core

Pipelined arg-max engine over a ROWS×COLS array of unsigned samples. On each `valid_in` it captures the whole array and reduces it through a pairwise compare tree. After a fixed latency it reports the maximum score and its (row, col) position. It sits after the fold/accumulate stage of the control datapath and feeds the peak-select logic.

## Interface
- `DATA_WIDTH`, 8: width of each unsigned array element.
- `ROWS`, 8: array rows; ≥2.
- `COLS`, 8: array columns; ≥2.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `valid_in`  in  1  array_in is valid this cycle; captured on the same edge.
- `array_in`  in  DATA_WIDTH × [ROWS][COLS]  unpacked unsigned input array.
- `max`  out  DATA_WIDTH+2  winning score, unsigned.
- `max_index_row`  out  $clog2(ROWS)  row of winner.
- `max_index_col`  out  $clog2(COLS)  column of winner.
- `valid_out`  out  1  one-cycle pulse; result outputs valid.

## Operation
- Score per cell (default): the element value zero-extended to DATA_WIDTH+2.
- Candidates are ordered row-major by flat index k = r·COLS + c.
- Reduction is a binary tree of compare nodes.
  - Each node keeps the candidate with the larger score.
  - On equal scores the lower flat index wins.
  - The overall winner is therefore the lowest-index maximum.
- Odd candidate counts at a level: the last candidate passes through unchanged.
- All arithmetic is unsigned; no saturation is needed, since the max score fits DATA_WIDTH+2.
- Outputs are registered and hold the last result until the next `valid_out`.
- Reset clears every pipeline valid bit and sets `max`, `max_index_row`, `max_index_col` and `valid_out` to 0.
- Reset mid-operation: in-flight inputs are discarded, and no `valid_out` is produced for them.
- `valid_in` asserted in the same cycle as `rst`: ignored.

## Timing
- Fully pipelined: accepts `valid_in` every cycle, with no backpressure.
- Latency L = 1 + $clog2(ROWS·COLS) cycles from the `valid_in` edge to the `valid_out` edge. L = 7 for 8×8.
  - Stage 0 registers the scored array.
  - Each following stage registers one tree level.
- `valid_out` is high exactly one cycle per accepted input, in input order.
- N back-to-back inputs produce N consecutive pulses.
- Data presented without `valid_in` is ignored, and results are not disturbed.

## Configuration
- `MAX_SUM_INDEX_SUM4_EN` undefined: score = element value (as above).
- `MAX_SUM_INDEX_SUM4_EN` defined: score = sum of the 2×2 window anchored at (r,c), i.e. [r][c]+[r][c+1]+[r+1][c]+[r+1][c+1].
  - Out-of-range neighbours count as 0.
  - The sum is computed combinationally before stage 0, so latency is unchanged.
  - The reported index is the window anchor.

## Structure
- Package `max_sum_index_pkg`, holding:
  - a parameterised candidate struct {score, row, col};
  - the compare function `better(a,b)`, which implements max with the lower-index tie-break;
  - the latency constant computation.
- Sub-module `max_fold_stage`: one registered tree level that maps N candidates to ceil(N/2) and carries the valid bit.
- The top level instantiates it in a generate loop across the $clog2(ROWS·COLS) levels.

## Test plan
- 8×8 input with array_in[i][j]=i·8+j and [1][1]=255, one-cycle `valid_in` -> 7 cycles later a single `valid_out` with max=255, row=1, col=1.
- All-zero array -> max=0 at (0,0).
- Ties: [2][3]=[5][0]=250, all others <250 -> max=250 at (2,3).
- Two consecutive `valid_in` cycles (ramp, then [7][7]=200 with others 0) -> two consecutive pulses: (255,1,1), then (200,7,7).
- `rst` asserted 3 cycles after `valid_in` -> outputs 0 and no `valid_out` pulse.
- With `MAX_SUM_INDEX_SUM4_EN`, all elements 255 -> max=1020 at (0,0).

Source files
------------

// File: rtl/max_sum_index_pkg.sv
// max_sum_index_pkg: shared types and helpers for the arg-max pipeline.
//   cand_t      - candidate record {score, row, col}. Its field widths are set by
//                 package localparams and are wide enough for any instance. Each
//                 module keeps its own exact-width copy and widens it only to
//                 compare.
//   better()    - 1 when candidate a beats or ties candidate b. The larger score
//                 wins. On equal scores the lower row-major index wins.
//   level_width - number of candidates left after a given number of tree levels.
//   latency     - cycles from the driving edge of valid_in to the valid_out edge.
// Optional feature macro (used by the top level): MAX_SUM_INDEX_SUM4_EN.
package max_sum_index_pkg;

    localparam int SCORE_W_MAX = 32;
    localparam int IDX_W_MAX   = 16;

    typedef struct packed {
        logic [SCORE_W_MAX-1:0] score;
        logic [IDX_W_MAX-1:0]   row;
        logic [IDX_W_MAX-1:0]   col;
    } cand_t;

    function automatic logic better(input cand_t a, input cand_t b);
        if (a.score != b.score) return a.score > b.score;
        if (a.row != b.row)     return a.row < b.row;
        return a.col <= b.col;
    endfunction

    function automatic int level_width(input int n, input int lvl);
        int w;
        w = n;
        for (int i = 0; i < lvl; i++) w = (w + 1) / 2;
        return w;
    endfunction

    function automatic int latency(input int rows, input int cols);
        return 1 + $clog2(rows * cols);
    endfunction

endpackage

// File: rtl/max_fold_stage.sv
// max_fold_stage: one registered level of the arg-max compare tree.
//   clk, rst          - clock; synchronous active-high reset
//   valid_in, cand_in - N_IN packed candidates {score,row,col}, index 0 in the LSBs
//   valid_out         - valid bit delayed by one cycle
//   cand_out          - ceil(N_IN/2) winners, registered
// Candidate 2i is paired with candidate 2i+1. If N_IN is odd, the last candidate
// has no partner and passes through unchanged.
module max_fold_stage
    import max_sum_index_pkg::*;
#(
    parameter int N_IN    = 2,
    parameter int SCORE_W = 10,
    parameter int ROW_W   = 3,
    parameter int COL_W   = 3
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                valid_in,
    input  logic [N_IN*(SCORE_W+ROW_W+COL_W)-1:0]               cand_in,
    output logic                                                valid_out,
    output logic [((N_IN+1)/2)*(SCORE_W+ROW_W+COL_W)-1:0]       cand_out
);

    localparam int CW    = SCORE_W + ROW_W + COL_W;
    localparam int N_OUT = (N_IN + 1) / 2;

    function automatic cand_t widen(input logic [CW-1:0] x);
        cand_t w;
        w.score = SCORE_W_MAX'(x[CW-1 -: SCORE_W]);
        w.row   = IDX_W_MAX'(x[ROW_W+COL_W-1 -: ROW_W]);
        w.col   = IDX_W_MAX'(x[COL_W-1:0]);
        return w;
    endfunction

    logic [N_OUT*CW-1:0] folded;

    for (genvar i = 0; i < N_OUT; i++) begin : g_node
        if (2*i + 1 < N_IN) begin : g_pair
            logic [CW-1:0] a;
            logic [CW-1:0] b;
            assign a = cand_in[(2*i)*CW +: CW];
            assign b = cand_in[(2*i+1)*CW +: CW];
            assign folded[i*CW +: CW] = better(widen(a), widen(b)) ? a : b;
        end else begin : g_pass
            assign folded[i*CW +: CW] = cand_in[(2*i)*CW +: CW];
        end
    end

    // NOTE: non-blocking assignments make every stage sample its predecessor's
    // pre-edge value. Without them the pipeline would collapse in simulation.
    // Data loads only with valid, so idle cycles cannot disturb a held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            // NOTE: the data is reset as well as the valid bit, because after
            // reset the final stage is the visible output and must read 0.
            cand_out  <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) cand_out <= folded;
        end
    end

endmodule

// File: rtl/max_sum_index_core.sv
// max_sum_index_core: pipelined arg-max over a ROWS x COLS array of unsigned samples.
//   clk, rst        - clock; synchronous active-high reset
//   valid_in        - array_in is captured on this edge
//   array_in        - [ROWS][COLS] unsigned samples, DATA_WIDTH bits each
//   max             - winning score (DATA_WIDTH+2 bits)
//   max_index_row   - row of the winner (the window anchor in SUM4 mode)
//   max_index_col   - column of the winner
//   valid_out       - one-cycle pulse per accepted input, in input order
// The score of each cell is computed combinationally and registered in stage 0.
// Each following register is one level of the compare tree. The lowest-index
// maximum wins.
// Optional feature: define MAX_SUM_INDEX_SUM4_EN to score each cell with its 2x2
// window sum. Neighbours outside the array count as 0.
module max_sum_index_core
    import max_sum_index_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    input  logic [DATA_WIDTH-1:0]       array_in [ROWS][COLS],
    output logic [DATA_WIDTH+1:0]       max,
    output logic [$clog2(ROWS)-1:0]     max_index_row,
    output logic [$clog2(COLS)-1:0]     max_index_col,
    output logic                        valid_out
);

    localparam int N       = ROWS * COLS;
    localparam int SCORE_W = DATA_WIDTH + 2;
    localparam int ROW_W   = $clog2(ROWS);
    localparam int COL_W   = $clog2(COLS);
    localparam int CW      = SCORE_W + ROW_W + COL_W;
    localparam int LEVELS  = $clog2(N);

    // Flat candidate bus, row-major: candidate k = r*COLS + c is at [k*CW +: CW].
    logic [N*CW-1:0] scored;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [SCORE_W-1:0] score;
`ifdef MAX_SUM_INDEX_SUM4_EN
            logic [SCORE_W-1:0] right;
            logic [SCORE_W-1:0] down;
            logic [SCORE_W-1:0] diag;
            if (c + 1 < COLS) begin : g_right
                assign right = SCORE_W'(array_in[r][c+1]);
            end else begin : g_right_zero
                assign right = '0;
            end
            if (r + 1 < ROWS) begin : g_down
                assign down = SCORE_W'(array_in[r+1][c]);
            end else begin : g_down_zero
                assign down = '0;
            end
            if (c + 1 < COLS && r + 1 < ROWS) begin : g_diag
                assign diag = SCORE_W'(array_in[r+1][c+1]);
            end else begin : g_diag_zero
                assign diag = '0;
            end
            // Four DATA_WIDTH-bit terms fit in DATA_WIDTH+2 bits, so the sum
            // cannot overflow.
            assign score = SCORE_W'(array_in[r][c]) + right + down + diag;
`else
            assign score = SCORE_W'(array_in[r][c]);
`endif
            assign scored[(r*COLS + c)*CW +: CW] = {score, ROW_W'(r), COL_W'(c)};
        end
    end

    // Stage 0: register the scored array.
    logic            s0_vld;
    logic [N*CW-1:0] s0_cand;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld  <= 1'b0;
            s0_cand <= '0;
        end else begin
            s0_vld <= valid_in;
            if (valid_in) s0_cand <= scored;
        end
    end

    // One registered fold per tree level. Level l narrows the candidate set
    // from level_width(N,l) to level_width(N,l+1).
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N_IN  = level_width(N, l);
        localparam int N_OUT = level_width(N, l + 1);

        logic                src_vld;
        logic [N_IN*CW-1:0]  src;
        logic                dst_vld;
        logic [N_OUT*CW-1:0] dst;

        if (l == 0) begin : g_first
            assign src_vld = s0_vld;
            assign src     = s0_cand;
        end else begin : g_next
            assign src_vld = g_lvl[l-1].dst_vld;
            assign src     = g_lvl[l-1].dst;
        end

        max_fold_stage #(
            .N_IN    (N_IN),
            .SCORE_W (SCORE_W),
            .ROW_W   (ROW_W),
            .COL_W   (COL_W)
        ) u_fold (
            .clk       (clk),
            .rst       (rst),
            .valid_in  (src_vld),
            .cand_in   (src),
            .valid_out (dst_vld),
            .cand_out  (dst)
        );
    end

    // The last fold holds exactly one candidate. Its registers drive the outputs.
    logic [CW-1:0] winner;
    assign winner        = g_lvl[LEVELS-1].dst;
    assign max           = winner[CW-1 -: SCORE_W];
    assign max_index_row = winner[ROW_W+COL_W-1 -: ROW_W];
    assign max_index_col = winner[COL_W-1:0];
    assign valid_out     = g_lvl[LEVELS-1].dst_vld;

endmodule

// File: tb/tb_max_sum_index_core.sv
// Self-checking bench for max_sum_index_core (8x8, 8-bit). Table vectors are
// applied back-to-back. Expected results are queued when a vector is driven and
// popped when valid_out appears. Hand-written sequences cover hold, mid-flight
// reset, and valid_in during reset.
module tb_max_sum_index_core;

    localparam int DW  = 8;
    localparam int R   = 8;
    localparam int C   = 8;
    localparam int LAT = 7;

    typedef logic [DW-1:0] arr_t [R][C];

    typedef struct {
        string name;
        arr_t  arr;
        int    mx;
        int    mr;
        int    mc;
    } vec_t;

    typedef struct {
        int     mx;
        int     mr;
        int     mc;
        longint due;
        string  name;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              valid_in;
    arr_t              array_in;
    logic [DW+1:0]     max_score;
    logic [2:0]        max_row;
    logic [2:0]        max_col;
    logic              valid_out;

    int     n_tests  = 0;
    int     n_fail   = 0;
    int     pulses   = 0;
    int     pushes   = 0;
    longint cyc      = 0;
    exp_t   sb[$];

    max_sum_index_core #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .array_in      (array_in),
        .max           (max_score),
        .max_index_row (max_row),
        .max_index_col (max_col),
        .valid_out     (valid_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a linear scan that keeps the first strictly larger score.
    task automatic model(input arr_t a, output int mx, output int mr, output int mc);
        mx = -1; mr = 0; mc = 0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                int s;
                s = a[r][c];
`ifdef MAX_SUM_INDEX_SUM4_EN
                if (c + 1 < C) s += a[r][c+1];
                if (r + 1 < R) s += a[r+1][c];
                if (r + 1 < R && c + 1 < C) s += a[r+1][c+1];
`endif
                if (s > mx) begin mx = s; mr = r; mc = c; end
            end
        end
    endtask

    task automatic fill_const(output arr_t a, input int v);
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) a[r][c] = DW'(v);
    endtask

    task automatic fill_ramp(output arr_t a);
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) a[r][c] = DW'(r*C + c);
    endtask

    task automatic fill_rand(output arr_t a, input int hi);
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) a[r][c] = DW'($urandom_range(hi, 0));
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid_out) begin
            pulses++;
            if (sb.size() == 0) begin
                check("unexpected_valid_out", valid_out, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_max"}, max_score, e.mx);
                check({e.name, "_row"}, max_row, e.mr);
                check({e.name, "_col"}, max_col, e.mc);
                check({e.name, "_latency"}, cyc, e.due);
            end
        end
    end

    task automatic send(input string name, input arr_t a, input int mx, input int mr, input int mc);
        exp_t e;
        @(posedge clk); #1;
        array_in = a;
        valid_in = 1'b1;
        e.mx = mx; e.mr = mr; e.mc = mc; e.due = cyc + LAT; e.name = name;
        sb.push_back(e);
        pushes++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            arr_t g;
            @(posedge clk); #1;
            valid_in = 1'b0;
            fill_rand(g, 255);
            array_in = g;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_pending", sb.size(), 0);
    endtask

    vec_t vecs[8];
    int   last_mx, last_mr, last_mc;
    int   p0;

    initial begin
        arr_t a;
        int   mx, mr, mc;

        rst = 1'b1;
        valid_in = 1'b0;
        fill_const(a, 0);
        array_in = a;

        // Build the table. Expected values are hand-derived for score = element.
        vecs[0].name = "ramp_peak";  fill_ramp(vecs[0].arr); vecs[0].arr[1][1] = 8'd255;
        vecs[0].mx = 255; vecs[0].mr = 1; vecs[0].mc = 1;
        vecs[1].name = "corner77";   fill_const(vecs[1].arr, 0); vecs[1].arr[7][7] = 8'd200;
        vecs[1].mx = 200; vecs[1].mr = 7; vecs[1].mc = 7;
        vecs[2].name = "all_zero";   fill_const(vecs[2].arr, 0);
        vecs[2].mx = 0;   vecs[2].mr = 0; vecs[2].mc = 0;
        vecs[3].name = "tie_250";    fill_ramp(vecs[3].arr); vecs[3].arr[2][3] = 8'd250; vecs[3].arr[5][0] = 8'd250;
        vecs[3].mx = 250; vecs[3].mr = 2; vecs[3].mc = 3;
        vecs[4].name = "all_max";    fill_const(vecs[4].arr, 255);
`ifdef MAX_SUM_INDEX_SUM4_EN
        vecs[4].mx = 1020;
`else
        vecs[4].mx = 255;
`endif
        vecs[4].mr = 0; vecs[4].mc = 0;
        vecs[5].name = "top_right";  fill_const(vecs[5].arr, 1); vecs[5].arr[0][7] = 8'd128;
        vecs[5].mx = 128; vecs[5].mr = 0; vecs[5].mc = 7;
        vecs[6].name = "tie_last";   fill_const(vecs[6].arr, 8); vecs[6].arr[7][6] = 8'd9; vecs[6].arr[7][7] = 8'd9;
        vecs[6].mx = 9;   vecs[6].mr = 7; vecs[6].mc = 6;
        vecs[7].name = "tie_split";  fill_const(vecs[7].arr, 3); vecs[7].arr[3][7] = 8'd77; vecs[7].arr[4][0] = 8'd77;
        vecs[7].mx = 77;  vecs[7].mr = 3; vecs[7].mc = 7;
`ifdef MAX_SUM_INDEX_SUM4_EN
        // Window sums differ from element values, so take the scan model here.
        // The all-255 case keeps its hand value of 1020 at (0,0).
        for (int i = 0; i < 8; i++)
            if (i != 4) model(vecs[i].arr, vecs[i].mx, vecs[i].mr, vecs[i].mc);
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_max", max_score, 0);
        check("reset_row", max_row, 0);
        check("reset_col", max_col, 0);
        check("reset_valid_out", valid_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single isolated input: exactly one pulse, LAT cycles after the drive.
        p0 = pulses;
        send(vecs[0].name, vecs[0].arr, vecs[0].mx, vecs[0].mr, vecs[0].mc);
        idle(1);
        drain();
        idle(10);
        @(negedge clk);
        check("single_pulse_count", pulses - p0, 1);

        // Whole table back-to-back. Ramp followed by corner77 gives two adjacent pulses.
        p0 = pulses;
        for (int i = 0; i < 8; i++) send(vecs[i].name, vecs[i].arr, vecs[i].mx, vecs[i].mr, vecs[i].mc);
        idle(1);
        drain();
        check("burst_pulse_count", pulses - p0, 8);
        last_mx = vecs[7].mx; last_mr = vecs[7].mr; last_mc = vecs[7].mc;

        // Hold: new data without valid_in must not disturb the result.
        idle(12);
        @(negedge clk);
        check("hold_max", max_score, last_mx);
        check("hold_row", max_row, last_mr);
        check("hold_col", max_col, last_mc);

        // Reset three cycles after valid_in: no pulse, outputs cleared.
        p0 = pulses;
        @(posedge clk); #1;
        array_in = vecs[0].arr;
        valid_in = 1'b1;
        idle(3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(12);
        @(negedge clk);
        check("midreset_pulses", pulses - p0, 0);
        check("midreset_max", max_score, 0);
        check("midreset_row", max_row, 0);
        check("midreset_col", max_col, 0);

        // valid_in together with rst is ignored.
        p0 = pulses;
        @(posedge clk); #1;
        array_in = vecs[1].arr;
        valid_in = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        valid_in = 1'b0;
        idle(12);
        @(negedge clk);
        check("rst_valid_pulses", pulses - p0, 0);
        check("rst_valid_max", max_score, 0);

        // Random back-to-back vectors. The small value range forces many ties.
        for (int i = 0; i < 6; i++) begin
            fill_rand(a, (i < 3) ? 15 : 255);
            model(a, mx, mr, mc);
            send($sformatf("rand%0d", i), a, mx, mr, mc);
        end
        idle(1);
        drain();

        check("total_pulses", pulses, pushes);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the bench always terminates on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time bound");
        $fatal(1, "timeout");
    end

endmodule
